// File: rtl/beep_pkg.sv
// Shared types, identifiers and tone pattern tables for the buzzer scheduler.
package beep_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int NREQ     = 4;
    localparam int NSEG_MAX = 4;

    // Requester ids; a lower id means a higher priority.
    localparam logic [1:0] ID_GAMEOVER = 2'd0;
    localparam logic [1:0] ID_ERROR    = 2'd1;
    localparam logic [1:0] ID_OK       = 2'd2;
    localparam logic [1:0] ID_CLICK    = 2'd3;

    localparam logic [1:0] TONE_OFF = 2'd0;
    localparam logic [1:0] TONE_250 = 2'd1;
    localparam logic [1:0] TONE_500 = 2'd2;

    // Number of segments each pattern uses.
    localparam logic [2:0] pat_nseg [NREQ] = '{
        ID_GAMEOVER: 3'd4,
        ID_ERROR:    3'd3,
        ID_OK:       3'd1,
        ID_CLICK:    3'd1
    };

    // Tone code per segment; unused segments are silent.
    localparam logic [1:0] pat_tone [NREQ][NSEG_MAX] = '{
        ID_GAMEOVER: '{TONE_250, TONE_500, TONE_250, TONE_500},
        ID_ERROR:    '{TONE_250, TONE_OFF, TONE_250, TONE_OFF},
        ID_OK:       '{TONE_500, TONE_OFF, TONE_OFF, TONE_OFF},
        ID_CLICK:    '{TONE_500, TONE_OFF, TONE_OFF, TONE_OFF}
    };

    // Segment duration in ms ticks (1..250); unused segments are 0.
    localparam logic [7:0] pat_ms [NREQ][NSEG_MAX] = '{
        ID_GAMEOVER: '{8'd250, 8'd250, 8'd250, 8'd250},
        ID_ERROR:    '{8'd250, 8'd250, 8'd250, 8'd0},
        ID_OK:       '{8'd125, 8'd0,   8'd0,   8'd0},
        ID_CLICK:    '{8'd20,  8'd0,   8'd0,   8'd0}
    };

    function automatic logic [3:0] id_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    // Fixed-priority pick: the lowest set index wins.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    // True when some requester with higher priority than id is waiting.
    function automatic logic any_below(input logic [3:0] v, input logic [1:0] id);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && (i < int'(id))) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/beep_tone_gen.sv
// Tone source: free-running 2-bit divider and the registered buzzer drive.
module beep_tone_gen
    import beep_pkg::*;
(
    input  logic       clk,
    input  logic       st,
    input  logic [1:0] tone_sel,
    input  logic       en,
    output logic       beep
);

    logic [1:0] tc;
    logic       tone_bit;

    // Pick the divider tap for the requested tone.
    always_comb begin
        // NOTE: every path assigns tone_bit, so this stays combinational with no latch.
        case (tone_sel)
            TONE_250: tone_bit = tc[1];
            TONE_500: tone_bit = tc[0];
            default:  tone_bit = 1'b0;
        endcase
    end

    // Divider runs continuously; the buzzer is driven only while enabled.
    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            tc   <= '0;
            beep <= 1'b0;
        end else begin
            tc   <= tc + 2'd1;
            beep <= en & tone_bit;
        end
    end

endmodule

// File: rtl/beep_scheduler.sv
// Arbitrates four beep requesters onto one buzzer, sequencing each tone pattern.
// GAP_MS must be at least 1.
module beep_scheduler
    import beep_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int GAP_MS   = 50,
    parameter int PREEMPT  = 1
) (
    input  logic       clk,
    input  logic       st,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [3:0] done,
    output logic [3:0] aborted,
    output logic       busy,
    output logic       beep
);

    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int GW = $clog2(GAP_MS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_t        state;
    logic [3:0]    pending;
    logic [1:0]    id;
    logic [1:0]    seg;
    logic [7:0]    seg_cnt;
    logic [GW-1:0] gap_cnt;
    logic [PW-1:0] pre;

    logic [1:0] win;
    logic       take;
    logic       tick;
    logic       last_seg;
    logic [3:0] clr;

    // Arbitration, ms tick strobe and end-of-pattern detection.
    always_comb begin
        win      = lowest_idx(pending);
        tick     = (state != S_IDLE) && (pre == PRE_LAST);
        last_seg = ({1'b0, seg} == (pat_nseg[id] - 3'd1));
        take     = 1'b0;
        if (state == S_IDLE) begin
            take = |pending;
        end else if ((state == S_PLAY) && (PREEMPT != 0)) begin
            take = any_below(pending, id);
        end
        clr = take ? id_onehot(win) : 4'b0000;
    end

    // One-deep request latch per id; a new request beats a same-cycle grant clear.
    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            pending <= '0;
        end else begin
            // NOTE: non-blocking updates so every register here sees pre-edge values.
            pending <= (pending & ~clr) | req;
        end
    end

    // Sequencer: start/preempt, per-segment countdown, inter-pattern gap.
    // seg_cnt holds the ticks left in the segment, so the tick that would take
    // it to zero is the one that advances.
    always_ff @(posedge clk or negedge st) begin
        if (!st) begin
            state   <= S_IDLE;
            id      <= '0;
            seg     <= '0;
            seg_cnt <= '0;
            gap_cnt <= '0;
            pre     <= '0;
            grant   <= '0;
            done    <= '0;
            aborted <= '0;
        end else begin
            grant   <= '0;
            done    <= '0;
            aborted <= '0;
            if (take) begin
                if (state == S_PLAY) aborted <= id_onehot(id);
                state   <= S_PLAY;
                id      <= win;
                seg     <= '0;
                seg_cnt <= pat_ms[win][0];
                pre     <= '0;
                grant   <= id_onehot(win);
            end else if (tick) begin
                pre <= '0;
                if (state == S_PLAY) begin
                    if (seg_cnt == 8'd1) begin
                        if (last_seg) begin
                            state   <= S_GAP;
                            done    <= id_onehot(id);
                            seg     <= '0;
                            seg_cnt <= '0;
                            gap_cnt <= GW'(GAP_MS);
                        end else begin
                            seg     <= seg + 2'd1;
                            seg_cnt <= pat_ms[id][seg + 2'd1];
                        end
                    end else begin
                        seg_cnt <= seg_cnt - 8'd1;
                    end
                end else begin
                    if (gap_cnt == GW'(1)) begin
                        state   <= S_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
            end else if (state != S_IDLE) begin
                pre <= pre + PW'(1);
            end
        end
    end

    assign busy = (state != S_IDLE);

    beep_tone_gen u_tone (
        .clk      (clk),
        .st       (st),
        .tone_sel (pat_tone[id][seg]),
        .en       (state == S_PLAY),
        .beep     (beep)
    );

endmodule

// File: tb/tb_beep_scheduler.sv
// Scoreboard bench: one preempting and one non-preempting scheduler on shared stimulus.
module tb_beep_scheduler;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [3:0] d;
        logic [3:0] a;
    } ev_t;

    localparam int TONE_N = 8192;

    logic       clk = 1'b0;
    logic       st  = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant, done, aborted;
    logic       busy, beep;
    logic [3:0] grant_np, done_np, aborted_np;
    logic       busy_np, beep_np;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  beep_err = 0;
    ev_t q0[$];
    ev_t q1[$];
    int  tone_at [TONE_N];
    logic [1:0] m_tc;
    logic [1:0] tcb;
    logic       exp_b;
    int         t_now;

    int ms_t   [4][4] = '{'{250, 250, 250, 250}, '{250, 250, 250, 0}, '{125, 0, 0, 0}, '{20, 0, 0, 0}};
    int tone_t [4][4] = '{'{1, 2, 1, 2}, '{1, 0, 1, 0}, '{2, 0, 0, 0}, '{2, 0, 0, 0}};

    beep_scheduler #(.TICK_DIV(1), .GAP_MS(50), .PREEMPT(1)) dut (
        .clk(clk), .st(st), .req(req), .grant(grant), .done(done),
        .aborted(aborted), .busy(busy), .beep(beep)
    );

    beep_scheduler #(.TICK_DIV(1), .GAP_MS(50), .PREEMPT(0)) dut_np (
        .clk(clk), .st(st), .req(req), .grant(grant_np), .done(done_np),
        .aborted(aborted_np), .busy(busy_np), .beep(beep_np)
    );

    always #5 clk = ~clk;

    // Cycle index: number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Reference copy of the free-running tone divider.
    always @(posedge clk or negedge st) begin
        if (!st) m_tc <= '0;
        else     m_tc <= m_tc + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int inst, input int c, input logic [3:0] g, input logic [3:0] d,
                        input logic [3:0] a);
        ev_t e;
        e.cyc = c; e.g = g; e.d = d; e.a = a;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic push_both(input int c, input logic [3:0] g, input logic [3:0] d);
        push(0, c, g, d, 4'b0000);
        push(1, c, g, d, 4'b0000);
    endtask

    // Expected tone for pattern p granted at edge g: beep follows one edge later.
    task automatic fill(input int p, input int g);
        int o;
        o = g;
        for (int s = 0; s < 4; s++) begin
            for (int k = 1; k <= ms_t[p][s]; k++) begin
                if (o + k < TONE_N) tone_at[o + k] = tone_t[p][s];
            end
            o += ms_t[p][s];
        end
    endtask

    task automatic mon_events(input int inst, input logic [3:0] g, input logic [3:0] d,
                              input logic [3:0] a);
        ev_t e;
        int  sz;
        sz = (inst == 0) ? q0.size() : q1.size();
        while (sz > 0) begin
            e = (inst == 0) ? q0[0] : q1[0];
            if (e.cyc >= cyc) break;
            check($sformatf("i%0d_missed_event", inst), cyc, e.cyc);
            if (inst == 0) void'(q0.pop_front());
            else           void'(q1.pop_front());
            sz--;
        end
        if (|{g, d, a}) begin
            if (sz == 0) begin
                check($sformatf("i%0d_unexpected_event", inst), {20'd0, g, d, a}, 32'd0);
            end else begin
                e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("i%0d_event_cycle", inst), cyc, e.cyc);
                check($sformatf("i%0d_event_gda", inst), {20'd0, g, d, a}, {20'd0, e.g, e.d, e.a});
            end
        end
    endtask

    // Scoreboard and beep waveform monitor, sampled mid-cycle.
    always @(negedge clk) begin
        t_now = (cyc < TONE_N) ? tone_at[cyc] : 0;
        tcb   = m_tc - 2'd1;
        exp_b = (t_now == 1) ? tcb[1] : (t_now == 2) ? tcb[0] : 1'b0;
        if (beep !== exp_b) beep_err++;
        mon_events(0, grant, done, aborted);
        mon_events(1, grant_np, done_np, aborted_np);
    end

    task automatic wait_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse(input logic [3:0] m);
        req = m;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while ((busy || busy_np || q0.size() != 0 || q1.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_in_time"}, (n < limit) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_beep(input string tag);
        check({tag, "_beep_waveform"}, beep_err, 0);
        beep_err = 0;
    endtask

    initial begin
        int c;
        int g;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {18'd0, grant, done, aborted, busy, beep}, 32'd0);
        check("rst_outputs_np", {18'd0, grant_np, done_np, aborted_np, busy_np, beep_np}, 32'd0);
        #2 st = 1'b1;
        repeat (3) @(negedge clk);

        // Reset in the middle of GAMEOVER with OK pending
        c = cyc;
        pulse(4'b0001);
        g = c + 2;
        push_both(g, 4'b0001, 4'b0000);
        fill(0, g);
        wait_cycle(g + 290);
        pulse(4'b0100);
        wait_cycle(g + 300);
        if (beep == 1'b0) @(negedge clk);
        check("a_beep_high_before_rst", beep, 1);
        check("a_busy_before_rst", busy, 1);
        check("a_pending_before_rst", dut.pending, 4'b0100);
        for (int i = cyc + 1; i < TONE_N; i++) tone_at[i] = 0;
        #2 st = 1'b0;
        #1;
        check("a_rst_beep", beep, 0);
        check("a_rst_busy", busy, 0);
        check("a_rst_pending", dut.pending, 4'b0000);
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        #2 st = 1'b1;
        repeat (20) @(negedge clk);
        check("a_idle_after_rst", {busy, busy_np}, 2'b00);
        check_beep("a");

        // Single OK request
        c = cyc;
        pulse(4'b0100);
        g = c + 2;
        push_both(g, 4'b0100, 4'b0000);
        push_both(g + 125, 4'b0000, 4'b0100);
        fill(2, g);
        wait_cycle(g + 125 + 49);
        check("b_busy_in_gap", busy, 1);
        @(negedge clk);
        check("b_busy_fall", busy, 0);
        check("b_busy_fall_np", busy_np, 0);
        wait_idle("b", 100);
        check_beep("b");

        // Request held across its own grant: set wins, OK replays once
        c = cyc;
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
        g = c + 2;
        push_both(g, 4'b0100, 4'b0000);
        push_both(g + 125, 4'b0000, 4'b0100);
        push_both(g + 176, 4'b0100, 4'b0000);
        push_both(g + 301, 4'b0000, 4'b0100);
        fill(2, g);
        fill(2, g + 176);
        wait_idle("f", 600);
        check_beep("f");

        // ERROR and OK together: ERROR first, gap, then OK
        c = cyc;
        pulse(4'b0110);
        g = c + 2;
        push_both(g, 4'b0010, 4'b0000);
        push_both(g + 750, 4'b0000, 4'b0010);
        push_both(g + 801, 4'b0100, 4'b0000);
        push_both(g + 926, 4'b0000, 4'b0100);
        fill(1, g);
        fill(2, g + 801);
        wait_idle("c", 1200);
        check_beep("c");

        // CLICK preempted by GAMEOVER (waits when preemption is off); GAMEOVER re-requested twice
        c = cyc;
        pulse(4'b1000);
        g = c + 2;
        push_both(g, 4'b1000, 4'b0000);
        push(1, g + 20, 4'b0000, 4'b1000, 4'b0000);
        push(1, g + 71, 4'b0001, 4'b0000, 4'b0000);
        push(1, g + 1071, 4'b0000, 4'b0001, 4'b0000);
        fill(3, g);
        wait_cycle(g + 4);
        pulse(4'b0001);
        push(0, g + 6, 4'b0001, 4'b0000, 4'b1000);
        push(0, g + 1006, 4'b0000, 4'b0001, 4'b0000);
        fill(0, g + 6);
        wait_cycle(g + 406);
        pulse(4'b0001);
        push(0, g + 1057, 4'b0001, 4'b0000, 4'b0000);
        push(0, g + 2057, 4'b0000, 4'b0001, 4'b0000);
        push(1, g + 1122, 4'b0001, 4'b0000, 4'b0000);
        push(1, g + 2122, 4'b0000, 4'b0001, 4'b0000);
        fill(0, g + 1057);
        wait_cycle(g + 506);
        pulse(4'b0001);
        wait_idle("d", 2500);
        check_beep("d");

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
